// File: rtl/rsa_operand_loader.sv
// Streaming front/back end for rsa4k: assembles message/exponent/modulus from
// DATA_WIDTH words, pulses go, waits for done, then streams the cypher out.
// Optional watchdog on the rsa4k handshake enabled by RSA_LOADER_TIMEOUT_EN.
module rsa_operand_loader #(
  parameter int unsigned RSA_WIDTH      = 4096,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned WORDS          = RSA_WIDTH / DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [RSA_WIDTH-1:0]  message,
  output logic [RSA_WIDTH-1:0]  exponent,
  output logic [RSA_WIDTH-1:0]  modulus,
  output logic                  go,
  input  logic                  done,
  input  logic [RSA_WIDTH-1:0]  cypher,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned   CW        = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, ARM, WAIT_DONE, CAPTURE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        word_q;
  logic [1:0]           op_q;
  logic [RSA_WIDTH-1:0] shift_q;
  logic                 s_ready_q;
  logic                 s_fire, m_fire, last_beat, timeout;

  assign s_fire    = s_valid && s_ready_q;
  assign m_fire    = (state_q == STREAM) && m_ready;
  assign last_beat = (op_q == 2'd2) && (word_q == LAST_WORD);
  assign s_ready   = s_ready_q;
  assign m_data    = shift_q[DATA_WIDTH-1:0];

`ifdef RSA_LOADER_TIMEOUT_EN
  logic [24:0] wd_q;
  logic        err_q;
  logic        waiting;

  assign waiting = (state_q == ARM) || (state_q == WAIT_DONE);
  assign timeout = waiting && (wd_q == 25'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= waiting ? wd_q + 25'd1 : '0;
      if (timeout)
        err_q <= 1'b1;
      else if (s_fire && state_q == IDLE)
        err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE:      if (s_fire) state_d = LOAD;
      LOAD:      if (s_fire && last_beat) state_d = START;
      START: begin
        go      = 1'b1;
        state_d = ARM;
      end
      // ARM discards a done level left over from the previous run
      ARM: begin
        if (timeout)   state_d = IDLE;
        else if (!done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout)   state_d = IDLE;
        else if (done) state_d = CAPTURE;
      end
      CAPTURE:   state_d = STREAM;
      STREAM: begin
        m_valid = 1'b1;
        m_last  = (word_q == LAST_WORD);
        if (m_fire && word_q == LAST_WORD) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // s_ready is registered so it reads 0 during reset and in the cycle after it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q    <= '0;
      op_q      <= '0;
      message   <= '0;
      exponent  <= '0;
      modulus   <= '0;
      shift_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= (state_d == IDLE) || (state_d == LOAD);
      if (s_fire) begin
        unique case (op_q)
          2'd0:    message[int'(word_q) * DATA_WIDTH +: DATA_WIDTH]  <= s_data;
          2'd1:    exponent[int'(word_q) * DATA_WIDTH +: DATA_WIDTH] <= s_data;
          default: modulus[int'(word_q) * DATA_WIDTH +: DATA_WIDTH]  <= s_data;
        endcase
        word_q <= word_q + 1'b1;
        if (word_q == LAST_WORD)
          op_q <= (op_q == 2'd2) ? 2'd0 : op_q + 2'd1;
      end
      if (state_q == CAPTURE) begin
        shift_q <= cypher;
        word_q  <= '0;
      end else if (m_fire) begin
        shift_q <= shift_q >> DATA_WIDTH;
        word_q  <= word_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed, table-driven bench for rsa_operand_loader with a behavioural rsa4k stub.
module tb_rsa_operand_loader;

  localparam int unsigned RW = 4096;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = RW / DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [RW-1:0] message, exponent, modulus;
  logic          go;
  logic          done = 1'b0;
  logic [RW-1:0] cypher = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          err;

  rsa_operand_loader #(
    .RSA_WIDTH     (RW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .message (message),
    .exponent(exponent),
    .modulus (modulus),
    .go      (go),
    .done    (done),
    .cypher  (cypher),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned go_cnt = 0;

  always @(posedge clk) if (go === 1'b1) go_cnt <= go_cnt + 1;

  typedef struct {
    logic [63:0] msg0, exp0, mod0, cyp0;
    logic [31:0] seed;       // operand fill seed, 0 = remaining words zero
    logic [31:0] cseed;      // cypher fill seed
    bit          rnd_valid;
    int unsigned stale;      // cycles done stays at its old level after go
    int          stall_word; // output word held with m_ready low for 10 cycles
    logic [63:0] exp_first;
    logic [63:0] exp_w17;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int k = NW - 1; k >= 0; k--)
      if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s word %0d: got 0x%0h expected 0x%0h", name, bad,
               act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [63:0] w0, input logic [31:0] seed);
    logic [RW-1:0] v;
    v = '0;
    v[63:0] = w0;
    if (seed != 0)
      for (int k = 1; k < NW; k++) v[k*DW +: DW] = {seed ^ 32'(k * 7), 32'(k)};
    return v;
  endfunction

  task automatic load(input logic [RW-1:0] m, input logic [RW-1:0] e, input logic [RW-1:0] d,
                      input bit rnd);
    logic [3*RW-1:0] all;
    int idx;
    bit v, rdy, early_go;
    all = {d, e, m};
    idx = 0;
    early_go = 1'b0;
    for (int cyc = 0; cyc < 3000 && idx < 3 * NW; cyc++) begin
      v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      rdy = s_ready;
      s_valid = v;
      s_data = all[idx*DW +: DW];
      @(negedge clk);
      if (v && rdy) idx++;
      if (go === 1'b1 && idx < 3 * NW) early_go = 1'b1;
    end
    s_valid = 1'b0;
    check("beats_accepted", 64'(idx), 64'(3 * NW));
    check("no_early_go", {63'd0, early_go}, 64'd0);
    check("go_after_last", {63'd0, go}, 64'd1);
    check("s_ready_drop", {63'd0, s_ready}, 64'd0);
    check_wide("message", message, m);
    check_wide("exponent", exponent, e);
    check_wide("modulus", modulus, d);
  endtask

  // Entered at the negedge where go is high
  task automatic stub(input int unsigned stale, input logic [RW-1:0] c);
    bit early;
    early = 1'b0;
    for (int unsigned i = 0; i < stale; i++) @(negedge clk);
    done = 1'b0;
    for (int unsigned i = stale; i < 100; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    cypher = c;
    done = 1'b1;
    check("quiet_until_done", {63'd0, early}, 64'd0);
    @(negedge clk);
    check("capture_gap", {63'd0, m_valid}, 64'd0);
    @(negedge clk);
    check("done_to_valid", {63'd0, m_valid}, 64'd1);
  endtask

  task automatic unload(input logic [RW-1:0] c, input int stall_word, input int reset_word,
                        output int n, output logic [63:0] w17);
    int stall;
    bit r;
    n = 0;
    stall = 0;
    w17 = 'x;
    for (int cyc = 0; cyc < 500 && n < NW; cyc++) begin
      if (n == reset_word) return;
      check("m_valid", {63'd0, m_valid}, 64'd1);
      check("m_data", m_data, c[n*DW +: DW]);
      check("m_last", {63'd0, m_last}, {63'd0, n == NW - 1});
      if (n == 17) w17 = m_data;
      r = !(n == stall_word && stall < 10);
      if (!r) stall++;
      m_ready = r;
      @(negedge clk);
      if (r) n++;
    end
    m_ready = 1'b0;
  endtask

  task automatic run(input vec_t t, input int reset_word);
    logic [RW-1:0] m, e, d, c;
    logic [63:0] w17;
    int n;
    int unsigned g0;
    m = mk(t.msg0, t.seed);
    e = mk(t.exp0, (t.seed == 0) ? 32'd0 : t.seed + 1);
    d = mk(t.mod0, (t.seed == 0) ? 32'd0 : t.seed + 2);
    c = mk(t.cyp0, t.cseed);
    g0 = go_cnt;
    load(m, e, d, t.rnd_valid);
    s_valid = 1'b1;
    s_data = 64'hBAD0_BAD0_BAD0_BAD0;
    stub(t.stale, c);
    s_valid = 1'b0;
    check("one_go", 64'(go_cnt - g0), 64'd1);
    check("first_word", m_data, t.exp_first);
    unload(c, t.stall_word, reset_word, n, w17);
    if (reset_word < 0) begin
      check("words_out", 64'(n), 64'(NW));
      check("word17", w17, t.exp_w17);
      check("end_m_valid", {63'd0, m_valid}, 64'd0);
      check("end_busy", {63'd0, busy}, 64'd0);
      check("end_s_ready", {63'd0, s_ready}, 64'd1);
      check_wide("message_held", message, m);
      check_wide("exponent_held", exponent, e);
      check_wide("modulus_held", modulus, d);
    end
  endtask

  initial begin
    vec_t tv[4];
    bit saw_valid;
    logic [RW-1:0] z;
    tv[0] = '{64'd5, 64'd3, 64'd33, 64'h1A, 32'h0, 32'h0, 1'b0, 0, -1,
              64'h1A, 64'h0};
    tv[1] = '{64'h1, 64'h10001, 64'hFFFF_0000_1234_5677, 64'hDEAD_BEEF_0000_0001,
              32'h1111_0000, 32'h2222_0000, 1'b1, 0, -1,
              64'hDEAD_BEEF_0000_0001, 64'h2222_0077_0000_0011};
    tv[2] = '{64'h2, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF,
              32'h3333_0000, 32'h4444_1000, 1'b0, 0, 17,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h4444_1077_0000_0011};
    tv[3] = '{64'h7, 64'h11, 64'h13, 64'h8000_0000_0000_0000,
              32'h5555_0000, 32'h6666_00FF, 1'b0, 2, -1,
              64'h8000_0000_0000_0000, 64'h6666_0088_0000_0011};

    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_go", {63'd0, go}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check_wide("rst_message", message, '0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_s_ready", {63'd0, s_ready}, 64'd1);

    for (int i = 0; i < 4; i++) run(tv[i], -1);

    // Asynchronous reset while word 30 is on the output
    run(tv[1], 30);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("mid_rst_m_data", m_data, 64'd0);
    check("mid_rst_m_last", {63'd0, m_last}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_go", {63'd0, go}, 64'd0);
    check_wide("mid_rst_message", message, '0);
    check_wide("mid_rst_modulus", modulus, '0);
    #3 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    run(tv[2], -1);

`ifdef RSA_LOADER_TIMEOUT_EN
    saw_valid = 1'b0;
    z = mk(64'h7, 32'h0);
    load(z, z, z, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 990; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("err_before_timeout", {63'd0, err}, 64'd0);
    check("busy_while_waiting", {63'd0, busy}, 64'd1);
    repeat (15) @(negedge clk);
    check("err_after_timeout", {63'd0, err}, 64'd1);
    check("idle_after_timeout", {63'd0, busy}, 64'd0);
    check("no_stream_on_timeout", {63'd0, saw_valid}, 64'd0);
    check_wide("message_kept", message, z);
    run(tv[0], -1);
    check("err_cleared", {63'd0, err}, 64'd0);
`else
    saw_valid = 1'b0;
    z = '0;
    check("err_tied_low", {63'd0, err | saw_valid | z[0]}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/rsa_operand_loader.md
Name: rsa_operand_loader

Overview:
- Streaming front/back end for the rsa4k top.
- Accepts message, exponent and modulus as a 64-bit word stream and assembles them into three 4096-bit operand registers driving rsa4k.
- Issues the one-cycle go pulse, waits for rsa4k done, then streams the 4096-bit cypher back out as 64-bit words.
- Sits directly upstream and downstream of rsa4k; all rsa4k operands are held stable from go until the last output word is accepted.

Parameters:
- RSA_WIDTH, 4096, operand width in bits.
- DATA_WIDTH, 64, stream word width in bits.
- WORDS, RSA_WIDTH/DATA_WIDTH (64), words per operand.
- TIMEOUT_CYCLES, 2**24, watchdog limit; used only with RSA_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  DATA_WIDTH  input operand word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a word this cycle.
- message  out  RSA_WIDTH  to rsa4k.message.
- exponent  out  RSA_WIDTH  to rsa4k.exponent.
- modulus  out  RSA_WIDTH  to rsa4k.modulus.
- go  out  1  one-cycle start pulse to rsa4k.
- done  in  1  rsa4k done (level, cleared by rsa4k after go).
- cypher  in  RSA_WIDTH  rsa4k result.
- m_data  out  DATA_WIDTH  output cypher word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data.
- m_last  out  1  marks word WORDS-1 of the cypher.
- busy  out  1  high in every state except IDLE.
- err  out  1  watchdog fired (0 when feature absent).

Behaviour:
- Reset (reset=0, asynchronous), outputs and state:
  - state=IDLE, word/operand counters=0.
  - message, exponent, modulus = 0.
  - go=0, s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, err=0.
- States: IDLE, LOAD, START, ARM, WAIT_DONE, CAPTURE, STREAM.
- IDLE:
  - s_ready=1.
  - The first s_valid beat is stored and the state moves to LOAD.
  - err clears on this first beat.
- LOAD:
  - s_ready=1; a beat is stored on s_valid&&s_ready.
  - Fixed order: message words 0..63, then exponent 0..63, then modulus 0..63. Least-significant word first.
  - Word k of an operand is written to bits [k*DATA_WIDTH +: DATA_WIDTH].
  - Word counter (6 bits) wraps 63->0 and advances a 2-bit operand index.
  - After beat 192 is accepted, s_ready drops the next cycle and the state moves to START.
  - s_valid low stalls LOAD indefinitely; no timeout applies in LOAD.
- START:
  - go=1 for exactly one cycle, then ARM.
- ARM:
  - Waits for done==0, which discards the stale done from the previous run; then WAIT_DONE.
  - If done is already 0, ARM lasts one cycle.
- WAIT_DONE:
  - On done==1, the state moves to CAPTURE.
- CAPTURE:
  - cypher is latched into an internal 4096-bit shift register.
  - Next cycle: STREAM with m_valid=1 and m_data = word 0.
- STREAM:
  - On m_valid&&m_ready, the register shifts right by DATA_WIDTH and the next word is presented.
  - m_last=1 while word 63 is presented.
  - When word 63 is accepted, m_valid=0 and the state returns to IDLE.
  - m_ready low holds m_data/m_valid stable (AXI-stream rules).
  - In IDLE, s_ready=1 the cycle after the last word is accepted.
- Stability:
  - message/exponent/modulus change only in LOAD.
  - s_ready=0 in START, ARM, WAIT_DONE, CAPTURE and STREAM; input beats offered there are not consumed.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all reset values.
  - A partially streamed result is lost; no go is issued.
- Latency:
  - Last input beat to go: 1 cycle.
  - done high to first m_valid: 2 cycles.

Optional Feature:
- Macro: RSA_LOADER_TIMEOUT_EN.
- Defined:
  - A 25-bit watchdog counts cycles in ARM and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: err=1 (sticky), state=IDLE, no output stream; operand registers retain their values.
  - err clears on the first accepted input beat of the next load.
- Undefined:
  - No counter is implemented; err is tied to 0 and WAIT_DONE waits forever.

Test Plan:
- Basic run, rsa4k stubbed:
  - Stimulus: stream 192 words with message word0=5, exponent word0=3, modulus word0=33, all other words 0; stub done rises 100 cycles after go with cypher=0x1A.
  - Response: one go pulse; m_data word0=0x1A, words 1..63=0; m_last only on word 63; busy falls after the last word.
- Input backpressure:
  - Stimulus: s_valid toggled randomly during load.
  - Response: exactly 192 beats are stored; message/exponent/modulus match bit-exact; go is issued only after beat 192.
- Output backpressure:
  - Stimulus: m_ready held low for 10 cycles at word 17.
  - Response: m_data holds word 17 stable; no word lost or duplicated.
- Stale done:
  - Stimulus: stub keeps done=1 for 2 cycles after go.
  - Response: loader stays in ARM/WAIT_DONE; it streams only after done goes 0 and then 1.
- Reset mid-stream:
  - Stimulus: reset pulsed low asynchronously at word 30 of the output.
  - Response: all outputs at reset values immediately; s_ready=1 after release; a new 192-word load works.
- Timeout (RSA_LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=1000):
  - Stimulus: done never rises.
  - Response: err=1 at cycle 1000 of waiting; no m_valid; err clears on the next input beat.
